orb_wr_arbiter: RTL and testbench
=================================

Name: orb_wr_arbiter

Overview:
Write-port arbiter for the double-buffered orbital frame RAM. It collects write requests from up to N_REQ packers (fast packer groups 1/2, slow packers 1/2) that currently drive a priority mux. Each requester gets a one-word holding slot. The block grants one slot per clock by round-robin and drives a single registered write port (WE/address/word) toward the ramM16 pair ahead of the SW bank steering.

Parameters:
N_REQ, 4, number of requesters (fast1, fast2, slow1, slow2 in index order)
AW, 11, write address width
DW, 12, orbital word width

Ports:
clk  in  1  system clock (80 MHz domain)
rst  in  1  asynchronous, active-high reset
iWE  in  N_REQ  per-requester write strobe, one cycle per word
iAddr  in  N_REQ*AW  packed addresses, requester k at bits [k*AW +: AW]
iData  in  N_REQ*DW  packed words, requester k at bits [k*DW +: DW]
iClrOvf  in  1  clears all overflow flags
oWE  out  1  write enable to frame RAM, registered
oAddr  out  AW  write address, registered
oData  out  DW  write word, registered
oGrant  out  N_REQ  one-hot; identifies the source of the current oWE
oPending  out  N_REQ  holding-slot valid bits
oOvf  out  N_REQ  sticky per-requester overflow flags

Behaviour:
- Reset: async assert clears all slots, oWE=0, oAddr=0, oData=0, oGrant=0, oPending=0, oOvf=0. Round-robin pointer is set to N_REQ-1, so requester 0 has top priority first.
- Outputs go to 0 immediately when rst asserts, even in the middle of a write. No pending word is written after rst deasserts.
- Slot load: on a clk edge with iWE[k]=1, slot k captures iAddr/iData k when the slot is empty or is being granted on that same edge. Bypass-on-drain lets a lone requester sustain one word per clock.
- Overflow: iWE[k]=1 while slot k is valid and not granted on that edge:
  - the new word is dropped;
  - the slot keeps its old word;
  - oOvf[k] is set.
- iClrOvf clears all flags. If iClrOvf and a new overflow occur on the same edge, the set wins for that bit.
- Arbitration: each edge, the block searches the valid slots starting at (ptr+1) mod N_REQ and wrapping. The first valid slot g is granted:
  - oWE<=1, oAddr/oData<=slot g, oGrant<=1<<g;
  - slot g is cleared unless it reloads on the same edge;
  - ptr<=g.
  - If no slot is valid: oWE<=0, oGrant<=0, oAddr/oData hold, ptr holds.
- Arbitration uses slot state from before the edge. A word arriving on edge t is not eligible until edge t+1.
- Latency: uncontested iWE sampled at edge t gives oWE high for the cycle after edge t+1 (2 clocks).
- Worst-case wait: a valid slot is granted within N_REQ edges.
- oGrant is one-hot or zero, never multi-hot. oWE equals the OR of oGrant.
- oPending reflects the registered slot valid bits.
- Address and data pass through unmodified. No width arithmetic; the pointer wraps modulo N_REQ.
- The FSM is implicit: the block is IDLE when no slot is valid and GRANT otherwise. There are no wait states.

Decomposition:
- Shared package orb_wr_pkg: ORB_AW=11, ORB_DW=12, ORB_NREQ=4, and requester index constants REQ_FAST1=0, REQ_FAST2=1, REQ_SLOW1=2, REQ_SLOW2=3.
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: valid vector, ptr.
  - Outputs: one-hot grant, encoded index, any.
  - Reused later for the UART buffer read scheduler.

Test Plan:
1. Req0 alone pulses iWE with addr 0x005, data 0xABC at edge t -> oWE=1, oGrant=0001, oAddr=0x005, oData=0xABC in the cycle after edge t+1; next cycle oWE=0, oPending=0000.
2. After reset, all four pulse iWE once, same edge, addr k, data 0x100+k -> grants 0001, 0010, 0100, 1000 on four consecutive cycles; data 0x100..0x103 in order; no overflow.
3. Req2 alone streams 8 consecutive words (addr 0..7) -> oWE high 8 consecutive cycles; addresses 0..7 in order; oOvf=0000.
4. Req0 and req1 both stream every cycle for 4 cycles -> grants alternate 0,1,0,1; oOvf=0011 sticky; accepted words are exactly those captured into empty or draining slots; iClrOvf then gives oOvf=0000.
5. Slot 3 pending, then rst asserted mid-cycle -> oWE/oGrant/oPending fall to 0 immediately; after release, no write appears; the next single req1 write is granted normally.
6. iClrOvf asserted on the same edge as a new req2 overflow -> oOvf[2]=1, other bits cleared.

Source files
------------

// File: rtl/orb_wr_pkg.sv
// rtl/orb_wr_pkg.sv - shared sizes and requester indices for the orbital frame write arbiter
package orb_wr_pkg;
  localparam int ORB_AW   = 11;
  localparam int ORB_DW   = 12;
  localparam int ORB_NREQ = 4;

  localparam int REQ_FAST1 = 0;
  localparam int REQ_FAST2 = 1;
  localparam int REQ_SLOW1 = 2;
  localparam int REQ_SLOW2 = 3;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts one past ptr_i and wraps
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [PW-1:0] cand;
    logic          found;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    found   = 1'b0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      cand = PW'((int'(ptr_i) + off) % N);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/orb_wr_arbiter.sv
// rtl/orb_wr_arbiter.sv - one-word-per-requester holding slots, round-robin drained into a registered RAM write port
module orb_wr_arbiter
  import orb_wr_pkg::*;
#(
  parameter int N_REQ = ORB_NREQ,
  parameter int AW    = ORB_AW,
  parameter int DW    = ORB_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]    iWE,
  input  logic [N_REQ*AW-1:0] iAddr,
  input  logic [N_REQ*DW-1:0] iData,
  input  logic               iClrOvf,
  output logic               oWE,
  output logic [AW-1:0]      oAddr,
  output logic [DW-1:0]      oData,
  output logic [N_REQ-1:0]    oGrant,
  output logic [N_REQ-1:0]    oPending,
  output logic [N_REQ-1:0]    oOvf
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] slot_vld_q, slot_vld_d;
  logic [AW-1:0]    slot_addr_q [N_REQ];
  logic [AW-1:0]    slot_addr_d [N_REQ];
  logic [DW-1:0]    slot_data_q [N_REQ];
  logic [DW-1:0]    slot_data_d [N_REQ];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    data_q, data_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;

  logic [N_REQ-1:0] pick_grant;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  // Picker sees only pre-edge slot state, so a word landing this edge waits one more.
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .valid_i (slot_vld_q),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    slot_vld_d  = slot_vld_q & ~pick_grant;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    ovf_d       = iClrOvf ? '0 : ovf_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (iWE[k]) begin
        if (!slot_vld_q[k] || pick_grant[k]) begin
          slot_vld_d[k]  = 1'b1;
          slot_addr_d[k] = iAddr[k*AW +: AW];
          slot_data_d[k] = iData[k*DW +: DW];
        end else begin
          ovf_d[k] = 1'b1;
        end
      end
    end
    we_d    = pick_any;
    grant_d = pick_grant;
    addr_d  = pick_any ? slot_addr_q[pick_idx] : addr_q;
    data_d  = pick_any ? slot_data_q[pick_idx] : data_q;
    ptr_d   = pick_any ? pick_idx : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        slot_addr_q[k] <= '0;
        slot_data_q[k] <= '0;
      end
      ptr_q   <= PW'(N_REQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
      ovf_q   <= '0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      ptr_q       <= ptr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      grant_q     <= grant_d;
      ovf_q       <= ovf_d;
    end
  end

  assign oWE      = we_q;
  assign oAddr    = addr_q;
  assign oData    = data_q;
  assign oGrant   = grant_q;
  assign oPending = slot_vld_q;
  assign oOvf     = ovf_q;

endmodule

// File: tb/tb_orb_wr_arbiter.sv
// tb/tb_orb_wr_arbiter.sv - directed self-checking bench for orb_wr_arbiter
module tb_orb_wr_arbiter;
  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    iWE;
  logic [N*AW-1:0] iAddr;
  logic [N*DW-1:0] iData;
  logic            iClrOvf;
  logic            oWE;
  logic [AW-1:0]   oAddr;
  logic [DW-1:0]   oData;
  logic [N-1:0]    oGrant;
  logic [N-1:0]    oPending;
  logic [N-1:0]    oOvf;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  orb_wr_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .iWE      (iWE),
    .iAddr    (iAddr),
    .iData    (iData),
    .iClrOvf  (iClrOvf),
    .oWE      (oWE),
    .oAddr    (oAddr),
    .oData    (oData),
    .oGrant   (oGrant),
    .oPending (oPending),
    .oOvf     (oOvf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iWE[k] = 1'b1;
    iAddr[k*AW +: AW] = a;
    iData[k*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iWE = '0; iAddr = '0; iData = '0; iClrOvf = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_we", 32'(oWE), 0);
    chk("rst_grant", 32'(oGrant), 0);
    chk("rst_pend", 32'(oPending), 0);
    chk("rst_ovf", 32'(oOvf), 0);
    chk("rst_addr", 32'(oAddr), 0);
    chk("rst_data", 32'(oData), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single word, two-clock latency
    put(0, 11'h005, 12'hABC);
    step();
    iWE = '0;
    chk("t1_pend_loaded", 32'(oPending), 32'b0001);
    chk("t1_we_early", 32'(oWE), 0);
    step();
    chk("t1_we", 32'(oWE), 1);
    chk("t1_grant", 32'(oGrant), 32'b0001);
    chk("t1_addr", 32'(oAddr), 32'h005);
    chk("t1_data", 32'(oData), 32'hABC);
    chk("t1_pend_drained", 32'(oPending), 0);
    step();
    chk("t1_we_off", 32'(oWE), 0);
    chk("t1_grant_off", 32'(oGrant), 0);

    // 2: all four on one edge, drained in index order
    do_reset();
    for (int k = 0; k < N; k++) put(k, AW'(k), DW'(12'h100 + k));
    step();
    iWE = '0;
    for (int k = 0; k < N; k++) begin
      step();
      chk("t2_we", 32'(oWE), 1);
      chk("t2_grant", 32'(oGrant), 32'(1 << k));
      chk("t2_data", 32'(oData), 32'h100 + k);
      chk("t2_addr", 32'(oAddr), k);
    end
    chk("t2_ovf", 32'(oOvf), 0);
    step();
    chk("t2_we_off", 32'(oWE), 0);

    // 3: lone requester streams via bypass-on-drain
    for (int i = 0; i < 10; i++) begin
      iWE = '0;
      if (i < 8) put(2, AW'(i), DW'(12'h200 + i));
      step();
      if (i >= 1 && i <= 8) begin
        chk("t3_we", 32'(oWE), 1);
        chk("t3_grant", 32'(oGrant), 32'b0100);
        chk("t3_addr", 32'(oAddr), i - 1);
        chk("t3_data", 32'(oData), 32'h200 + i - 1);
      end
    end
    iWE = '0;
    chk("t3_we_off", 32'(oWE), 0);
    chk("t3_ovf", 32'(oOvf), 0);

    // 4: two streamers contend; accepted a0,b0,a1,b2,a3
    do_reset();
    for (int i = 0; i < 4; i++) begin
      iWE = '0;
      put(0, AW'(12'h10 + i), DW'(12'h300 + i));
      put(1, AW'(12'h20 + i), DW'(12'h400 + i));
      step();
      if (i == 0) chk("t4_pend_both", 32'(oPending), 32'b0011);
      if (i == 1) begin
        chk("t4_g0", 32'(oGrant), 32'b0001);
        chk("t4_d0", 32'(oData), 32'h300);
        chk("t4_ovf_b", 32'(oOvf), 32'b0010);
      end
      if (i == 2) begin
        chk("t4_g1", 32'(oGrant), 32'b0010);
        chk("t4_d1", 32'(oData), 32'h400);
      end
      if (i == 3) begin
        chk("t4_g2", 32'(oGrant), 32'b0001);
        chk("t4_d2", 32'(oData), 32'h301);
      end
    end
    iWE = '0;
    step();
    chk("t4_g3", 32'(oGrant), 32'b0010);
    chk("t4_d3", 32'(oData), 32'h402);
    chk("t4_a3", 32'(oAddr), 32'h22);
    step();
    chk("t4_g4", 32'(oGrant), 32'b0001);
    chk("t4_d4", 32'(oData), 32'h303);
    step();
    chk("t4_idle", 32'(oWE), 0);
    chk("t4_ovf_sticky", 32'(oOvf), 32'b0011);
    iClrOvf = 1'b1;
    step();
    iClrOvf = 1'b0;
    chk("t4_ovf_clr", 32'(oOvf), 0);

    // 5: async reset while a write is on the port and slot 3 holds a word
    put(3, 11'h033, 12'h533);
    step();
    put(3, 11'h034, 12'h534);
    step();
    iWE = '0;
    chk("t5_we_pre", 32'(oWE), 1);
    chk("t5_pend_pre", 32'(oPending), 32'b1000);
    rst = 1'b1;
    #1;
    chk("t5_we_async", 32'(oWE), 0);
    chk("t5_grant_async", 32'(oGrant), 0);
    chk("t5_pend_async", 32'(oPending), 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("t5_no_write_a", 32'(oWE), 0);
    step();
    chk("t5_no_write_b", 32'(oWE), 0);
    put(1, 11'h7FF, 12'hFFF);
    step();
    iWE = '0;
    step();
    chk("t5_r1_we", 32'(oWE), 1);
    chk("t5_r1_grant", 32'(oGrant), 32'b0010);
    chk("t5_r1_addr", 32'(oAddr), 32'h7FF);
    chk("t5_r1_data", 32'(oData), 32'hFFF);

    // 6: clear and fresh overflow on the same edge, set wins
    iWE = '0;
    put(0, 11'h001, 12'h601);
    put(2, 11'h002, 12'h602);
    step();
    step();
    chk("t6_grant_s2", 32'(oGrant), 32'b0100);
    chk("t6_ovf_pre", 32'(oOvf), 32'b0001);
    iWE = '0;
    put(2, 11'h003, 12'h603);
    iClrOvf = 1'b1;
    step();
    iWE = '0;
    iClrOvf = 1'b0;
    chk("t6_grant_s0", 32'(oGrant), 32'b0001);
    chk("t6_ovf", 32'(oOvf), 32'b0100);
    step();
    chk("t6_drain_data", 32'(oData), 32'h602);
    step();
    chk("t6_idle", 32'(oWE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
